// File: rtl/app_tst_pkg.sv
// Shared state encoding, phase indices and mode constants for the SGDMA test sequencer.
package app_tst_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_USR_RW  = 3'd1,
    ST_CFG_RW  = 3'd2,
    ST_DMA0_RW = 3'd3,
    ST_DMA1_RW = 3'd4,
    ST_STREAM  = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  typedef enum logic {
    DIR_H2C = 1'b0,
    DIR_C2H = 1'b1
  } dir_t;

  localparam int PH_USR     = 0;
  localparam int PH_CFG     = 1;
  localparam int PH_DMA0    = 2;
  localparam int PH_DMA1    = 3;
  localparam int NUM_PHASES = 4;

  localparam logic [1:0] MD_LOOPBACK = 2'b11;

  // Register phases occupy consecutive encodings starting at ST_USR_RW.
  function automatic logic [1:0] phase_idx(input state_t s);
    logic [2:0] d;
    d = 3'(s) - 3'd1;
    return d[1:0];
  endfunction

  function automatic logic is_reg_phase(input state_t s);
    return (s == ST_USR_RW) || (s == ST_CFG_RW) || (s == ST_DMA0_RW) || (s == ST_DMA1_RW);
  endfunction

endpackage

// File: rtl/app_tst_slice_arb.sv
// Streaming-phase arbiter: loopback run or H2C/C2H time slices with a break-before-make gap.
// Build macro APP_TST_STAT_EN adds saturating grant-cycle counters.
module app_tst_slice_arb
  import app_tst_pkg::*;
#(
  parameter int SLICE_LEN = 1024
) (
  input  logic        usr_clk,
  input  logic        usr_rst_n,
  input  logic        active,
  input  logic [1:0]  md,
  input  logic        h2c_run,
  input  logic        c2h_run,
`ifdef APP_TST_STAT_EN
  input  logic        stat_clr,
  output logic [31:0] stat_h2c_cyc,
  output logic [31:0] stat_c2h_cyc,
`endif
  output logic        h2c_gnt,
  output logic        c2h_gnt,
  output logic        lp_run
);

  localparam logic [15:0] SLICE_LAST = 16'(SLICE_LEN - 1);

  dir_t        prio, prio_nxt, sel;
  logic [15:0] cnt, cnt_nxt;
  logic        h2c_req, c2h_req, cur_req, oth_req;
  logic        h2c_nxt, c2h_nxt, lp_nxt;

  always_comb begin
    h2c_req  = ~md[1] & h2c_run;
    c2h_req  = ~md[0] & c2h_run;
    cur_req  = 1'b0;
    oth_req  = 1'b0;
    sel      = DIR_H2C;
    h2c_nxt  = 1'b0;
    c2h_nxt  = 1'b0;
    lp_nxt   = 1'b0;
    prio_nxt = prio;
    cnt_nxt  = cnt;
    if (!active || (md == MD_LOOPBACK) || lp_run) begin
      // Loopback only rises once both grants are already low.
      prio_nxt = DIR_H2C;
      cnt_nxt  = '0;
      lp_nxt   = active & (md == MD_LOOPBACK) & ~(h2c_gnt | c2h_gnt);
    end else if (h2c_gnt || c2h_gnt) begin
      cur_req = h2c_gnt ? h2c_req : c2h_req;
      oth_req = h2c_gnt ? c2h_req : h2c_req;
      if (!cur_req || ((cnt == SLICE_LAST) && oth_req)) begin
        prio_nxt = h2c_gnt ? DIR_C2H : DIR_H2C;
      end else begin
        h2c_nxt = h2c_gnt;
        c2h_nxt = c2h_gnt;
        cnt_nxt = (cnt == SLICE_LAST) ? '0 : cnt + 16'd1;
      end
    end else if (h2c_req || c2h_req) begin
      if (prio == DIR_H2C) sel = h2c_req ? DIR_H2C : DIR_C2H;
      else                 sel = c2h_req ? DIR_C2H : DIR_H2C;
      h2c_nxt  = (sel == DIR_H2C);
      c2h_nxt  = (sel == DIR_C2H);
      prio_nxt = sel;
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      h2c_gnt <= 1'b0;
      c2h_gnt <= 1'b0;
      lp_run  <= 1'b0;
      prio    <= DIR_H2C;
      cnt     <= '0;
    end else begin
      h2c_gnt <= h2c_nxt;
      c2h_gnt <= c2h_nxt;
      lp_run  <= lp_nxt;
      prio    <= prio_nxt;
      cnt     <= cnt_nxt;
    end
  end

`ifdef APP_TST_STAT_EN
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      stat_h2c_cyc <= '0;
      stat_c2h_cyc <= '0;
    end else if (stat_clr) begin
      stat_h2c_cyc <= '0;
      stat_c2h_cyc <= '0;
    end else begin
      if (h2c_gnt && (stat_h2c_cyc != '1)) stat_h2c_cyc <= stat_h2c_cyc + 32'd1;
      if (c2h_gnt && (stat_c2h_cyc != '1)) stat_c2h_cyc <= stat_c2h_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/app_tst_sched.sv
// SGDMA test sequencer: power-on delay, four watchdogged register phases, then streaming.
// Build macro APP_TST_STAT_EN adds stat_h2c_cyc_o / stat_c2h_cyc_o.
module app_tst_sched
  import app_tst_pkg::*;
#(
  parameter int INIT_DLY  = 4010,
  parameter int PHASE_TMO = 50000,
  parameter int SLICE_LEN = 1024
) (
  input  logic        usr_clk,
  input  logic        usr_rst_n,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [1:0]  usr_lp0rw_md_i,
  input  logic        m0_axis_h2c_run_i,
  input  logic        s0_axis_c2h_run_i,
  input  logic [3:0]  phase_done_i,
  input  logic [3:0]  phase_err_i,
  output logic        usr_regrw_run_o,
  output logic        cfg_regrw_run_o,
  output logic [1:0]  dma_regrw_run_o,
  output logic        usr_h2c0w_run_o,
  output logic        usr_c2h0r_run_o,
  output logic        usr_lp0rw_run_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  err_o,
  output logic [3:0]  tmo_o,
  output logic [2:0]  state_o
`ifdef APP_TST_STAT_EN
  ,
  output logic [31:0] stat_h2c_cyc_o,
  output logic [31:0] stat_c2h_cyc_o
`endif
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_DLY - 1);
  localparam logic [15:0] TMO_LAST  = 16'(PHASE_TMO - 1);

  state_t                  state, state_nxt;
  logic [15:0]             cnt;
  logic                    in_phase, ph_done, ph_tmo, start_ok;
  logic [1:0]              ph;
  logic [NUM_PHASES-1:0]   run_nxt;

  always_comb begin
    state_nxt = state;
    in_phase  = is_reg_phase(state);
    ph        = phase_idx(state);
    ph_done   = in_phase & phase_done_i[ph];
    ph_tmo    = in_phase & (cnt == TMO_LAST);
    start_ok  = 1'b0;
    unique case (state)
      ST_INIT:    if (cnt == INIT_LAST) state_nxt = ST_USR_RW;
      ST_USR_RW, ST_CFG_RW, ST_DMA0_RW, ST_DMA1_RW:
                  if (ph_done || ph_tmo) state_nxt = state_t'(3'(state) + 3'd1);
      ST_STREAM:  if (stop_i) state_nxt = ST_DONE;
      ST_DONE: begin
        if (start_i) begin
          state_nxt = ST_INIT;
          start_ok  = 1'b1;
        end
      end
      default:    state_nxt = ST_INIT;
    endcase
  end

  // Run outputs are registered from the next state so they track the state register exactly.
  always_comb begin
    run_nxt          = '0;
    run_nxt[PH_USR]  = (state_nxt == ST_USR_RW);
    run_nxt[PH_CFG]  = (state_nxt == ST_CFG_RW);
    run_nxt[PH_DMA0] = (state_nxt == ST_DMA0_RW);
    run_nxt[PH_DMA1] = (state_nxt == ST_DMA1_RW);
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) state <= ST_INIT;
    else            state <= state_nxt;
  end

  // One counter serves both the INIT delay and the per-phase watchdog; it restarts on every state change.
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n)                                               cnt <= '0;
    else if ((state_nxt != state) || !(in_phase || state == ST_INIT)) cnt <= '0;
    else                                                          cnt <= cnt + 16'd1;
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      err_o <= '0;
      tmo_o <= '0;
    end else if (start_ok) begin
      err_o <= '0;
      tmo_o <= '0;
    end else if (ph_done) begin
      err_o[ph] <= err_o[ph] | phase_err_i[ph];
    end else if (ph_tmo) begin
      err_o[ph] <= 1'b1;
      tmo_o[ph] <= 1'b1;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      usr_regrw_run_o <= 1'b0;
      cfg_regrw_run_o <= 1'b0;
      dma_regrw_run_o <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      usr_regrw_run_o <= run_nxt[PH_USR];
      cfg_regrw_run_o <= run_nxt[PH_CFG];
      dma_regrw_run_o <= {run_nxt[PH_DMA1], run_nxt[PH_DMA0]};
      busy_o          <= (state_nxt != ST_DONE);
      done_o          <= (state_nxt == ST_DONE);
    end
  end

  assign state_o = state;

  app_tst_slice_arb #(
    .SLICE_LEN (SLICE_LEN)
  ) u_arb (
    .usr_clk      (usr_clk),
    .usr_rst_n    (usr_rst_n),
    .active       (state_nxt == ST_STREAM),
    .md           (usr_lp0rw_md_i),
    .h2c_run      (m0_axis_h2c_run_i),
    .c2h_run      (s0_axis_c2h_run_i),
`ifdef APP_TST_STAT_EN
    .stat_clr     (start_ok),
    .stat_h2c_cyc (stat_h2c_cyc_o),
    .stat_c2h_cyc (stat_c2h_cyc_o),
`endif
    .h2c_gnt      (usr_h2c0w_run_o),
    .c2h_gnt      (usr_c2h0r_run_o),
    .lp_run       (usr_lp0rw_run_o)
  );

endmodule

// File: doc/app_tst_sched.md
Name: app_tst_sched

Overview:
- Sequencer for the SGDMA test application.
- After power-on delay, steps through the register-access test phases one at a time, each with a done handshake and a timeout watchdog.
- Then enters a streaming phase. In that phase it either drives loopback or time-slices the H2C write and C2H read engines between themselves.
- Reports per-phase pass/fail and overall status. Sits between host-visible mode/run controls and the app test engines.

Parameters:
- INIT_DLY, 4010: cycles in INIT before the first phase.
- PHASE_TMO, 50000: watchdog limit, in cycles, for each register phase. Counter width is 16 bits; legal range 2..65535.
- SLICE_LEN, 1024: cycles per streaming grant slice. Counter width is 16 bits; legal range 1..65535.

Ports:
- usr_clk  in  1  clock.
- usr_rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; restarts the sequence from DONE.
- stop_i  in  1  pulse; ends STREAM.
- usr_lp0rw_md_i  in  2  mode. 2'b11 = loopback. bit1=0 enables H2C; bit0=0 enables C2H.
- m0_axis_h2c_run_i  in  1  H2C engine ready/requesting.
- s0_axis_c2h_run_i  in  1  C2H engine ready/requesting.
- phase_done_i  in  4  done pulses: [0] usr_regrw, [1] cfg_regrw, [2] dma_regrw0, [3] dma_regrw1.
- phase_err_i  in  4  error flag per phase; valid with the matching done pulse.
- usr_regrw_run_o  out  1  run, usr_regrw phase.
- cfg_regrw_run_o  out  1  run, cfg_regrw phase.
- dma_regrw_run_o  out  2  run, dma_regrw phases ([0], [1]).
- usr_h2c0w_run_o  out  1  H2C grant.
- usr_c2h0r_run_o  out  1  C2H grant.
- usr_lp0rw_run_o  out  1  loopback run.
- busy_o  out  1  high in every state except DONE.
- done_o  out  1  high in DONE.
- err_o  out  4  sticky per-phase fail (error or timeout).
- tmo_o  out  4  sticky per-phase timeout.
- state_o  out  3  current state encoding.

Behaviour:
- Clock and reset: clock usr_clk; reset usr_rst_n, asynchronous, active-low. All outputs are registered and reset to 0.
- After reset release, state = INIT. Every reset, including one mid-operation, returns to INIT with counters and err/tmo cleared.
- States: INIT -> USR_RW -> CFG_RW -> DMA0_RW -> DMA1_RW -> STREAM -> DONE.
- INIT:
  - cycle counter runs 0..INIT_DLY-1;
  - at count INIT_DLY-1, go to USR_RW.
- Register phase k (USR_RW = 0, CFG_RW = 1, DMA0_RW = 2, DMA1_RW = 3):
  - the matching run output is high on exactly the cycles the state register holds that phase (no gap, no overlap between phases);
  - the watchdog clears on entry;
  - on phase_done_i[k]: err_o[k] |= phase_err_i[k], then advance;
  - if the watchdog reaches PHASE_TMO-1 without done: err_o[k] and tmo_o[k] set to 1, then advance;
  - done in the same cycle as the timeout: done wins and tmo_o[k] is not set;
  - done pulses for phases other than the current one are ignored.
- A failed phase does not abort the sequence.
- STREAM, loopback (usr_lp0rw_md_i == 2'b11): usr_lp0rw_run_o = 1; H2C and C2H grants = 0.
- STREAM, otherwise:
  - h2c_req = ~md[1] & m0_axis_h2c_run_i;
  - c2h_req = ~md[0] & s0_axis_c2h_run_i;
  - arbitration is alternating time slices of SLICE_LEN cycles; H2C goes first after entering STREAM;
  - slice end with the other direction requesting: one cycle with both grants 0 (break-before-make), then grant the other direction;
  - slice end with the other direction not requesting: the current grant continues with no gap, and the slice counter reloads;
  - the granted direction drops its request: its grant deasserts next cycle and the arbiter switches immediately (with the 1-cycle gap);
  - neither direction requesting: both grants 0.
- Mode change in STREAM: the registered grants re-evaluate next cycle. Entering loopback drops both grants that cycle and raises lp0rw the following cycle.
- stop_i in STREAM: all stream outputs go to 0 next cycle and state goes to DONE. stop_i in any other state is ignored.
- DONE: start_i clears err/tmo and goes to INIT. start_i in any other state is ignored.
- Simultaneous start_i and stop_i in STREAM: stop wins; the start is dropped.

Optional Feature:
- Macro: APP_TST_STAT_EN.
- Defined: adds outputs stat_h2c_cyc_o[31:0] and stat_c2h_cyc_o[31:0].
  - each counts the cycles its grant is high;
  - each saturates at 0xFFFFFFFF;
  - each clears on reset and on start_i accepted in DONE.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package app_tst_pkg:
  - state encoding: INIT = 0, USR_RW = 1, CFG_RW = 2, DMA0_RW = 3, DMA1_RW = 4, STREAM = 5, DONE = 6;
  - phase index constants;
  - the loopback mode value 2'b11.
- Sub-module app_tst_slice_arb: streaming two-way time-slice arbiter, covering the slice counter, the gap cycle and the optional stat counters.

Test Plan:
- Reset, then every phase_done_i pulse 5 cycles after its run rises, with err = 0 -> run outputs sequence one at a time; first run rises at cycle INIT_DLY; err_o = 0; STREAM entered.
- CFG_RW given no done pulse -> cfg_regrw_run_o held exactly PHASE_TMO cycles; err_o = 4'b0010; tmo_o = 4'b0010; sequence continues to DMA0_RW.
- Done and timeout coincident in DMA1_RW with phase_err_i[3] = 0 -> tmo_o[3] = 0, err_o[3] = 0.
- STREAM, md = 00, both requests high, SLICE_LEN = 8 -> H2C 8 cycles, 1-cycle gap, C2H 8 cycles, and so on; grants never high together.
- STREAM, md = 01 (C2H disabled) -> H2C granted continuously with no gaps. Switch md to 11 -> H2C grant drops the next cycle, lp0rw rises one cycle later.
- stop_i in STREAM, then start_i -> done_o = 1, all run outputs 0; after start_i, err_o/tmo_o are cleared and INIT restarts. With APP_TST_STAT_EN defined, stat counters equal the grant-high cycle counts and then clear.
